// File: rtl/siren_pkg.sv
// Shared constants and types for the siren generator/detector pair.
// The generator uses the band-edge periods defined here.
package siren_pkg;

    localparam int CLK_HZ       = 25_000_000;
    localparam int CNT_W        = 17;
    localparam int PERIOD_400HZ = CLK_HZ / 400;
    localparam int PERIOD_700HZ = CLK_HZ / 700;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous pin, plus a third flop that
// produces a one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchroniser chain and edge-detect history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= async_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/siren_detector.sv
// Measures full periods of a square-wave audio input, classifies them
// against the siren band, tracks sweep direction and locks on a siren.
module siren_detector
    import siren_pkg::*;
#(
    parameter int CNT_W      = siren_pkg::CNT_W,
    parameter int MIN_PERIOD = 35000,
    parameter int MAX_PERIOD = 63000,
    parameter int TIMEOUT    = 126000,
    parameter int LOCK_COUNT = 8,
    parameter int HYST       = 4
) (
    input  logic             clock_25mhz,
    input  logic             reset_n,
    input  logic             audio_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_band,
    output logic             sweep_up,
    output logic             siren_detected
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int CW1    = CNT_W + 1;
    localparam logic [CNT_W-1:0]  MIN_P  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  MAX_P  = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0]  TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
    localparam logic [CW1-1:0]    HYST_X = CW1'(HYST);
    localparam logic [GOOD_W-1:0] LOCK_N = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0] G_ONE  = GOOD_W'(1);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  prev_r;
    logic [GOOD_W-1:0] good_cnt_r;
    logic              first_r;

    logic              rise_s;
    logic              timeout_s;
    logic              band_s;
    logic              faster_s;
    logic              slower_s;

    sync_edge_detect u_sync (
        .clk      (clock_25mhz),
        .rst_n    (reset_n),
        .async_in (audio_in),
        .rise     (rise_s)
    );

    // Widened by one bit so the hysteresis sums cannot wrap
    assign timeout_s = (cnt_r == TMO);
    assign band_s    = (cnt_r >= MIN_P) && (cnt_r <= MAX_P);
    assign faster_s  = ({1'b0, cnt_r} + HYST_X) < {1'b0, prev_r};
    assign slower_s  = {1'b0, cnt_r} > ({1'b0, prev_r} + HYST_X);

    // Period counter, measurement registers and lock state machine
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            prev_r         <= '0;
            good_cnt_r     <= '0;
            first_r        <= 1'b1;
            period         <= '0;
            period_valid   <= 1'b0;
            in_band        <= 1'b0;
            sweep_up       <= 1'b0;
            siren_detected <= 1'b0;
        end else begin
            period_valid   <= 1'b0;
            siren_detected <= (state_r == LOCKED);

            if (rise_s) begin
                cnt_r <= ONE;
            end else if (!timeout_s) begin
                cnt_r <= cnt_r + ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            if (rise_s && ((state_r == IDLE) || timeout_s)) begin
                // A stale count cannot be a period: restart as a first edge
                state_r        <= ACQUIRE;
                good_cnt_r     <= '0;
                first_r        <= 1'b1;
                siren_detected <= 1'b0;
                if (timeout_s) begin
                    in_band <= 1'b0;
                end
            end else if (rise_s) begin
                period       <= cnt_r;
                period_valid <= 1'b1;
                in_band      <= band_s;
                prev_r       <= cnt_r;
                first_r      <= 1'b0;
                if (!first_r) begin
                    if (faster_s) begin
                        sweep_up <= 1'b1;
                    end else if (slower_s) begin
                        sweep_up <= 1'b0;
                    end
                end
                case (state_r)
                    ACQUIRE: begin
                        if (!band_s) begin
                            good_cnt_r <= '0;
                        end else if (good_cnt_r >= (LOCK_N - G_ONE)) begin
                            good_cnt_r <= LOCK_N;
                            state_r    <= LOCKED;
                        end else begin
                            good_cnt_r <= good_cnt_r + G_ONE;
                        end
                    end
                    LOCKED: begin
                        if (!band_s) begin
                            good_cnt_r <= '0;
                            state_r    <= ACQUIRE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else if (timeout_s) begin
                state_r        <= IDLE;
                siren_detected <= 1'b0;
                in_band        <= 1'b0;
            end
        end
    end

endmodule
